// File: rtl/custom_ip_regif_pkg.sv
// rtl/custom_ip_regif_pkg.sv - shared register map and FSM encoding for the custom IP APB front-end
package custom_ip_regif_pkg;

  localparam int DATA_BASE     = 'h00;
  localparam int DATA_STRIDE   = 4;
  localparam int STATUS_OFFSET = 'h20;

  localparam int TIMEOUT_BIT  = 8;
  localparam int ADDR_ERR_BIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_REQ  = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/custom_ip_apb_regif.sv
// rtl/custom_ip_apb_regif.sv - APB slave decoding register writes into reg2ip strobes and shadowing ip2reg read-back
module custom_ip_apb_regif
  import custom_ip_regif_pkg::*;
#(
  parameter int NUM_REGS    = 3,
  parameter int ACK_TIMEOUT = 16,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [31:0]           pwdata_i,
  input  logic                  pwrite_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [NUM_REGS-1:0]   reg2ip_data_o,
  output logic [NUM_REGS-1:0]   reg2ip_en_o,
  input  logic [NUM_REGS-1:0]   reg2ip_ack_i,
  input  logic [NUM_REGS-1:0]   ip2reg_data_i,
  input  logic [NUM_REGS-1:0]   ip2reg_valid_i
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] sel_q, sel_d;
  logic [NUM_REGS-1:0] wdata_q, wdata_d;
  logic [NUM_REGS-1:0] en_q, en_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [31:0]         prdata_q, prdata_d;
  logic                timeout_err_q, timeout_err_d;
  logic                addr_err_q, addr_err_d;
  logic [NUM_REGS-1:0] shadow_q, shadow_d;
  logic [NUM_REGS-1:0] shadow_valid_q, shadow_valid_d;

  logic [NUM_REGS-1:0] dec_sel;
  logic                is_data, is_status, is_err, access;
  logic                timeout_set, timeout_clr, addr_err_set, addr_err_clr;
  logic [31:0]         status_word;
  logic                unused_pwdata;

  assign unused_pwdata = ^{pwdata_i[31:10], pwdata_i[7:1]};

  // Misaligned addresses never match a decode entry, so they fall into is_err.
  always_comb begin
    dec_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      dec_sel[i] = (paddr_i == ADDR_WIDTH'(DATA_BASE + DATA_STRIDE * i));
    end
  end

  assign is_data     = |dec_sel;
  assign is_status   = (paddr_i == ADDR_WIDTH'(STATUS_OFFSET));
  assign is_err      = !is_data && !is_status;
  assign access      = psel_i && penable_i && !pready_q;
  assign status_word = 32'(shadow_valid_q)
                     | (32'(timeout_err_q) << TIMEOUT_BIT)
                     | (32'(addr_err_q) << ADDR_ERR_BIT);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    en_d         = '0;
    cnt_d        = cnt_q;
    pready_d     = 1'b0;
    pslverr_d    = 1'b0;
    prdata_d     = '0;
    timeout_set  = 1'b0;
    timeout_clr  = 1'b0;
    addr_err_set = 1'b0;
    addr_err_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (pwrite_i && is_data) begin
            sel_d   = dec_sel;
            wdata_d = (wdata_q & ~dec_sel) | (dec_sel & {NUM_REGS{pwdata_i[0]}});
            en_d    = dec_sel;
            cnt_d   = '0;
            state_d = ST_WR_REQ;
          end else begin
            state_d  = ST_RESP;
            pready_d = 1'b1;
            if (is_err) begin
              pslverr_d    = 1'b1;
              addr_err_set = 1'b1;
            end else if (!pwrite_i) begin
              prdata_d = is_status ? status_word : {31'b0, |(shadow_q & dec_sel)};
            end else begin
              timeout_clr  = pwdata_i[TIMEOUT_BIT];
              addr_err_clr = pwdata_i[ADDR_ERR_BIT];
            end
          end
        end
      end
      ST_WR_REQ: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        // Counter holds cycles since the strobe, so the timeout response lands ACK_TIMEOUT cycles after it.
        if (|(reg2ip_ack_i & sel_q)) begin
          state_d  = ST_RESP;
          pready_d = 1'b1;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          pready_d    = 1'b1;
          pslverr_d   = 1'b1;
          timeout_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    timeout_err_d = (timeout_err_q & ~timeout_clr) | timeout_set;
    addr_err_d    = (addr_err_q & ~addr_err_clr) | addr_err_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      wdata_q       <= '0;
      en_q          <= '0;
      cnt_q         <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      prdata_q      <= '0;
      timeout_err_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      wdata_q       <= wdata_d;
      en_q          <= en_d;
      cnt_q         <= cnt_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      prdata_q      <= prdata_d;
      timeout_err_q <= timeout_err_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Shadow capture runs every cycle regardless of the APB transaction in flight.
  always_comb begin
    shadow_d       = (shadow_q & ~ip2reg_valid_i) | (ip2reg_data_i & ip2reg_valid_i);
    shadow_valid_d = shadow_valid_q | ip2reg_valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q       <= '0;
      shadow_valid_q <= '0;
    end else begin
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  assign prdata_o      = prdata_q;
  assign pready_o      = pready_q;
  assign pslverr_o     = pslverr_q;
  assign reg2ip_data_o = wdata_q;
  assign reg2ip_en_o   = en_q;

endmodule

// File: tb/tb_custom_ip_apb_regif.sv
// tb/tb_custom_ip_apb_regif.sv - directed self-checking bench for custom_ip_apb_regif
module tb_custom_ip_apb_regif;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i;
  logic        pwrite_i, psel_i, penable_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [2:0]  reg2ip_data_o, reg2ip_en_o, reg2ip_ack_i;
  logic [2:0]  ip2reg_data_i, ip2reg_valid_i;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ack_mode = 0;
  int en_cnt = 0, en_cyc = 0, en_run = 0, en_maxrun = 0, onehot_bad = 0, pr_cnt = 0;
  logic [2:0] en_last = '0;

  custom_ip_apb_regif dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .pwrite_i(pwrite_i), .psel_i(psel_i), .penable_i(penable_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .reg2ip_data_o(reg2ip_data_o), .reg2ip_en_o(reg2ip_en_o), .reg2ip_ack_i(reg2ip_ack_i),
    .ip2reg_data_i(ip2reg_data_i), .ip2reg_valid_i(ip2reg_valid_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Core model: mode 1 acks one cycle after the strobe, mode 2 holds ack high, mode 0 never acks.
  always @(posedge clk_i) begin
    logic [2:0] e;
    e = reg2ip_en_o;
    #1;
    if (ack_mode == 1) reg2ip_ack_i = e;
    else if (ack_mode == 2) reg2ip_ack_i = 3'b111;
    else reg2ip_ack_i = 3'b000;
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (|reg2ip_en_o) begin
        en_cnt++;
        en_last = reg2ip_en_o;
        en_cyc  = cyc;
        en_run++;
        if (en_run > en_maxrun) en_maxrun = en_run;
        if (!$onehot(reg2ip_en_o)) onehot_bad++;
      end else begin
        en_run = 0;
      end
      if (pready_o) pr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat, output int pr_cyc);
    @(posedge clk_i);
    #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = addr; pwdata_i = wdata;
    @(posedge clk_i);
    #1;
    penable_i = 1'b1;
    lat = 0;
    @(negedge clk_i);
    while (!pready_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    if (lat >= 100) chk("pready_wait_bound", 32'(lat), 32'd0);
    rdata  = prdata_o;
    err    = pslverr_o;
    pr_cyc = cyc;
    @(posedge clk_i);
    #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, pcyc;
  logic [11:0] rd_addr [4] = '{12'h000, 12'h004, 12'h008, 12'h020};
  logic [31:0] rd_exp  [4] = '{32'h1, 32'h0, 32'h1, 32'h7};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    reg2ip_ack_i = '0; ip2reg_data_i = '0; ip2reg_valid_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {prdata_o, 1'b0}, 33'd0);
    chk("reset_flags", {26'd0, pready_o, pslverr_o, reg2ip_data_o, reg2ip_en_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Write 1 to DATA_1, ack one cycle after the strobe
    ack_mode = 1;
    en_cnt = 0;
    apb_xfer(1'b1, 12'h004, 32'h1, rd, er, lat, pcyc);
    chk("wr1_latency", 32'(lat), 32'd3);
    chk("wr1_err", 32'(er), 32'd0);
    chk("wr1_en_count", 32'(en_cnt), 32'd1);
    chk("wr1_en_value", 32'(en_last), 32'h2);
    chk("wr1_data", 32'(reg2ip_data_o), 32'h2);

    // Shadow capture then read-back
    @(posedge clk_i); #1;
    ip2reg_valid_i = 3'b111; ip2reg_data_i = 3'b101;
    @(posedge clk_i); #1;
    ip2reg_valid_i = 3'b000; ip2reg_data_i = 3'b000;
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b0, rd_addr[i], 32'h0, rd, er, lat, pcyc);
      chk($sformatf("rd_0x%0h_data", rd_addr[i]), rd, rd_exp[i]);
      chk($sformatf("rd_0x%0h_latency", rd_addr[i]), 32'(lat), 32'd1);
      chk($sformatf("rd_0x%0h_err", rd_addr[i]), 32'(er), 32'd0);
    end

    // Ack timeout on DATA_2
    ack_mode = 0;
    en_cnt = 0;
    apb_xfer(1'b1, 12'h008, 32'h1, rd, er, lat, pcyc);
    chk("to_err", 32'(er), 32'd1);
    chk("to_latency", 32'(lat), 32'd17);
    chk("to_strobe_to_pready", 32'(pcyc - en_cyc), 32'd16);
    chk("to_en_value", 32'(en_last), 32'h4);
    apb_xfer(1'b0, 12'h020, 32'h0, rd, er, lat, pcyc);
    chk("to_status", rd, 32'h107);
    apb_xfer(1'b1, 12'h020, 32'h100, rd, er, lat, pcyc);
    chk("w1c_err", 32'(er), 32'd0);
    chk("w1c_latency", 32'(lat), 32'd1);
    apb_xfer(1'b0, 12'h020, 32'h0, rd, er, lat, pcyc);
    chk("w1c_status", rd, 32'h007);

    // Address errors: unmapped and misaligned
    en_cnt = 0;
    apb_xfer(1'b0, 12'h030, 32'h0, rd, er, lat, pcyc);
    chk("aerr_030_err", 32'(er), 32'd1);
    chk("aerr_030_rdata", rd, 32'h0);
    apb_xfer(1'b1, 12'h005, 32'h1, rd, er, lat, pcyc);
    chk("aerr_005_err", 32'(er), 32'd1);
    chk("aerr_no_strobe", 32'(en_cnt), 32'd0);
    chk("aerr_data_kept", 32'(reg2ip_data_o), 32'h6);
    apb_xfer(1'b0, 12'h020, 32'h0, rd, er, lat, pcyc);
    chk("aerr_status", rd, 32'h207);

    // Back-to-back writes with ack held high
    ack_mode = 2;
    en_cnt = 0;
    en_maxrun = 0;
    apb_xfer(1'b1, 12'h000, 32'h1, rd, er, lat, pcyc);
    chk("b2b_1_latency", 32'(lat), 32'd3);
    chk("b2b_1_data0", 32'(reg2ip_data_o[0]), 32'd1);
    apb_xfer(1'b1, 12'h000, 32'h0, rd, er, lat, pcyc);
    chk("b2b_2_latency", 32'(lat), 32'd3);
    chk("b2b_2_data0", 32'(reg2ip_data_o[0]), 32'd0);
    chk("b2b_en_count", 32'(en_cnt), 32'd2);
    chk("b2b_en_single_cycle", 32'(en_maxrun), 32'd1);
    chk("en_onehot", 32'(onehot_bad), 32'd0);

    // Reset during WR_WAIT
    ack_mode = 0;
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 12'h004; pwdata_i = 32'h0;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("rst_pre_data", 32'(reg2ip_data_o), 32'h4);
    rst_ni = 1'b0;
    #1;
    chk("rst_async_outputs", {prdata_o[30:0], pready_o}, 32'd0);
    chk("rst_async_flags", {27'd0, pslverr_o, reg2ip_data_o[2], reg2ip_data_o[1:0], |reg2ip_en_o}, 32'd0);
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    en_cnt = 0; pr_cnt = 0;
    rst_ni = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("rst_no_strobe", 32'(en_cnt), 32'd0);
    chk("rst_no_pready", 32'(pr_cnt), 32'd0);
    apb_xfer(1'b0, 12'h020, 32'h0, rd, er, lat, pcyc);
    chk("rst_status", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
